// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: shared class, funct3 and state encodings for branch resolution
package branch_resolve_pkg;
  typedef enum logic [1:0] {CLS_COND = 2'b00, CLS_JAL = 2'b01, CLS_JALR = 2'b10, CLS_NONE = 2'b11} cls_t;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;
endpackage

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: decoded-instruction inputs and redirect/link/counter outputs
interface branch_resolve_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic [XLEN-1:0] pc_in;
  logic [11:0]     code;
  logic            is_branch;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd;
  logic            origin_pc;
  logic [XLEN-1:0] pc_branch;
  logic            squash;
  logic            link_we;
  logic [4:0]      link_rd;
  logic [XLEN-1:0] link_data;
  logic            misalign;
  logic [15:0]     br_count;
  logic [15:0]     taken_count;
  modport master (
    output in_valid, pc_in, code, is_branch, imm, rs1_val, rs2_val, rd,
    input  origin_pc, pc_branch, squash, link_we, link_rd, link_data, misalign, br_count, taken_count
  );
  modport slave (
    input  in_valid, pc_in, code, is_branch, imm, rs1_val, rs2_val, rd,
    output origin_pc, pc_branch, squash, link_we, link_rd, link_data, misalign, br_count, taken_count
  );
endinterface

// File: rtl/branch_cmp.sv
// branch_cmp: conditional-branch outcome from funct3 and the two source operands
module branch_cmp
  import branch_resolve_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken
);
  // unlisted funct3 encodings resolve as not taken
  always_comb
    taken = (funct3 == F3_BEQ)  ? (a == b) :
            (funct3 == F3_BNE)  ? (a != b) :
            (funct3 == F3_BLT)  ? ($signed(a) <  $signed(b)) :
            (funct3 == F3_BGE)  ? ($signed(a) >= $signed(b)) :
            (funct3 == F3_BLTU) ? (a <  b) :
            (funct3 == F3_BGEU) ? (a >= b) : 1'b0;
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: resolves branches/jumps, redirects fetch, squashes wrong-path slots
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input logic             clk,
  input logic             reset,
  branch_resolve_if.slave bus
);
  state_t          state, state_nx;
  logic [1:0]      cnt, cnt_nx;
  cls_t            cls;
  logic            cond_taken, act, taken, aligned, redirect, link;
  logic [XLEN-1:0] target;
  logic            unused;
  assign unused = ^bus.code[9:3];
  assign cls = cls_t'(bus.code[11:10]);
  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3(bus.code[2:0]),
    .a     (bus.rs1_val),
    .b     (bus.rs2_val),
    .taken (cond_taken)
  );
  assign act      = bus.in_valid && bus.is_branch && state == IDLE && cls != CLS_NONE;
  assign taken    = act && (cls != CLS_COND || cond_taken);
  assign target   = (cls == CLS_JALR) ? {(bus.rs1_val[XLEN-1:1] + bus.imm[XLEN-1:1] + XLEN'(bus.rs1_val[0] & bus.imm[0]) >> 0), 1'b0} & {{(XLEN-1){1'b1}}, 1'b0}
                                      : bus.pc_in + bus.imm;
  assign aligned  = target[1:0] == 2'b00;
  assign redirect = taken && aligned;
  assign link     = redirect && cls != CLS_COND && bus.rd != 5'd0;
  // next state: a redirect opens a flush window that counts down to IDLE
  always_comb begin
    state_nx = (state == IDLE) ? (redirect ? FLUSH : IDLE) : (cnt == 2'd1 ? IDLE : FLUSH);
    cnt_nx   = (state == IDLE) ? (redirect ? 2'(FLUSH_CYCLES) : 2'd0) : cnt - 2'd1;
  end
  // state and flush counter register
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  // registered redirect, squash, link and saturating counters
  always_ff @(posedge clk)
    if (reset) begin
      bus.origin_pc   <= 1'b0;
      bus.pc_branch   <= '0;
      bus.squash      <= 1'b0;
      bus.link_we     <= 1'b0;
      bus.link_rd     <= 5'd0;
      bus.link_data   <= '0;
      bus.misalign    <= 1'b0;
      bus.br_count    <= 16'd0;
      bus.taken_count <= 16'd0;
    end else begin
      bus.origin_pc <= redirect;
      bus.squash    <= state == FLUSH;
      bus.misalign  <= taken && !aligned;
      bus.link_we   <= link;
      if (taken) bus.pc_branch <= target;
      if (link) begin
        bus.link_rd   <= bus.rd;
        bus.link_data <= bus.pc_in + XLEN'(4);
      end
      if (act && bus.br_count != 16'hFFFF) bus.br_count <= bus.br_count + 16'd1;
      if (taken && bus.taken_count != 16'hFFFF) bus.taken_count <= bus.taken_count + 16'd1;
    end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed checks of redirect, squash, link, misalign and counters
module tb_branch_resolve;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  branch_resolve_if #(.XLEN(32)) br0 ();
  branch_resolve_if #(.XLEN(32)) br3 ();
  branch_resolve #(.XLEN(32), .FLUSH_CYCLES(1)) u0 (.clk(clk), .reset(reset), .bus(br0));
  branch_resolve #(.XLEN(32), .FLUSH_CYCLES(3)) u3 (.clk(clk), .reset(reset), .bus(br3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive0(input logic v, input logic [11:0] c, input logic [31:0] pc, input logic [31:0] im,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    br0.in_valid = v; br0.is_branch = v; br0.code = c; br0.pc_in = pc;
    br0.imm = im; br0.rs1_val = a; br0.rs2_val = b; br0.rd = r;
  endtask
  task automatic drive3(input logic v, input logic [11:0] c, input logic [31:0] pc, input logic [31:0] im,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    br3.in_valid = v; br3.is_branch = v; br3.code = c; br3.pc_in = pc;
    br3.imm = im; br3.rs1_val = a; br3.rs2_val = b; br3.rd = r;
  endtask
  initial begin
    drive0(0, 12'h000, 0, 0, 0, 0, 0);
    drive3(0, 12'h000, 0, 0, 0, 0, 0);
    tick;
    tick;
    reset = 1'b0;
    chk("rst_origin", br0.origin_pc, 0);
    chk("rst_pcb", br0.pc_branch, 0);
    chk("rst_squash", br0.squash, 0);
    chk("rst_link", {br0.link_we, br0.link_rd}, 0);
    chk("rst_ldata", br0.link_data, 0);
    chk("rst_mis", br0.misalign, 0);
    chk("rst_cnt", {br0.br_count, br0.taken_count}, 0);
    drive0(1, 12'h000, 32'h100, 32'h20, 5, 5, 0);
    tick;
    chk("beq_origin", br0.origin_pc, 1);
    chk("beq_pcb", br0.pc_branch, 32'h120);
    chk("beq_squash0", br0.squash, 0);
    drive0(0, 12'h000, 0, 0, 0, 0, 0);
    tick;
    chk("beq_origin_off", br0.origin_pc, 0);
    chk("beq_squash1", br0.squash, 1);
    chk("beq_pcb_hold", br0.pc_branch, 32'h120);
    tick;
    chk("beq_squash_end", br0.squash, 0);
    chk("beq_counts", {br0.br_count, br0.taken_count}, {16'd1, 16'd1});
    drive0(1, 12'h004, 32'h200, 32'h8, 32'hFFFF_FFFF, 1, 0);
    tick;
    chk("blt_origin", br0.origin_pc, 1);
    chk("blt_pcb", br0.pc_branch, 32'h208);
    drive0(0, 12'h000, 0, 0, 0, 0, 0);
    tick;
    drive0(1, 12'h006, 32'h200, 32'h8, 32'hFFFF_FFFF, 1, 0);
    tick;
    chk("bltu_origin", br0.origin_pc, 0);
    chk("bltu_pcb_hold", br0.pc_branch, 32'h208);
    chk("bltu_counts", {br0.br_count, br0.taken_count}, {16'd3, 16'd2});
    drive0(1, 12'h801, 32'h300, 32'h0, 32'h203, 0, 1);
    tick;
    chk("jalr_pcb", br0.pc_branch, 32'h202);
    chk("jalr_mis", br0.misalign, 1);
    chk("jalr_origin", br0.origin_pc, 0);
    chk("jalr_link", br0.link_we, 0);
    chk("jalr_counts", {br0.br_count, br0.taken_count}, {16'd4, 16'd3});
    drive0(1, 12'hC00, 32'h300, 32'h4, 7, 7, 3);
    tick;
    chk("nonctl_mis", br0.misalign, 0);
    chk("nonctl_origin", br0.origin_pc, 0);
    chk("nonctl_br", br0.br_count, 4);
    drive0(1, 12'h400, 32'h40, 32'h10, 0, 0, 5);
    tick;
    chk("jal_origin", br0.origin_pc, 1);
    chk("jal_pcb", br0.pc_branch, 32'h50);
    chk("jal_link_we", br0.link_we, 1);
    chk("jal_link_rd", br0.link_rd, 5);
    chk("jal_link_data", br0.link_data, 32'h44);
    drive0(1, 12'h000, 32'h300, 32'h4, 9, 9, 0);
    tick;
    chk("flush_ign_origin", br0.origin_pc, 0);
    chk("flush_ign_squash", br0.squash, 1);
    chk("flush_ign_pcb", br0.pc_branch, 32'h50);
    chk("flush_ign_link", br0.link_we, 0);
    chk("flush_ign_counts", {br0.br_count, br0.taken_count}, {16'd5, 16'd4});
    drive0(0, 12'h000, 0, 0, 0, 0, 0);
    tick;
    drive0(1, 12'h400, 32'h80, 32'h20, 0, 0, 0);
    tick;
    chk("jal_rd0_origin", br0.origin_pc, 1);
    chk("jal_rd0_pcb", br0.pc_branch, 32'hA0);
    chk("jal_rd0_link", br0.link_we, 0);
    chk("jal_rd0_ldata", br0.link_data, 32'h44);
    reset = 1'b1;
    drive0(1, 12'h000, 32'h100, 32'h20, 5, 5, 0);
    tick;
    reset = 1'b0;
    chk("rstfl_origin", br0.origin_pc, 0);
    chk("rstfl_squash", br0.squash, 0);
    chk("rstfl_pcb", br0.pc_branch, 0);
    chk("rstfl_link", {br0.link_we, br0.link_rd}, 0);
    chk("rstfl_ldata", br0.link_data, 0);
    chk("rstfl_counts", {br0.br_count, br0.taken_count}, 0);
    drive0(0, 12'h000, 0, 0, 0, 0, 0);
    tick;
    chk("rstfl_after_squash", br0.squash, 0);
    drive3(1, 12'h000, 32'h100, 32'h20, 5, 5, 0);
    tick;
    chk("f3_origin1", br3.origin_pc, 1);
    chk("f3_pcb1", br3.pc_branch, 32'h120);
    chk("f3_squash0", br3.squash, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("f3_flush_origin", br3.origin_pc, 0);
      chk("f3_flush_squash", br3.squash, 1);
    end
    tick;
    chk("f3_origin2", br3.origin_pc, 1);
    chk("f3_squash_end", br3.squash, 0);
    chk("f3_counts", {br3.br_count, br3.taken_count}, {16'd2, 16'd2});
    drive3(0, 12'h000, 0, 0, 0, 0, 0);
    tick;
    drive0(1, 12'h800, 32'h0, 32'h0, 32'h202, 0, 0);
    for (int i = 0; i < 65536; i++) tick;
    chk("sat_br", br0.br_count, 16'hFFFF);
    chk("sat_taken", br0.taken_count, 16'hFFFF);
    tick;
    chk("sat_br_hold", br0.br_count, 16'hFFFF);
    chk("sat_taken_hold", br0.taken_count, 16'hFFFF);
    chk("sat_origin", br0.origin_pc, 0);
    drive0(0, 12'h000, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data and address width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1, range 1..3, meaning wrong-path slots squashed after a redirect.
REQ-003 SHALL have clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have reset  input  1  synchronous, active-high.
REQ-005 SHALL have in_valid  input  1  decoded instruction present this cycle.
REQ-006 SHALL have pc_in  input  32  address of the presented instruction.
REQ-007 SHALL have code  input  12  decoder op code; code[11:10] is the class (00 conditional, 01 JAL, 10 JALR, 11 non-control); code[2:0] is funct3.
REQ-008 SHALL have is_branch  input  1  decoder control-transfer flag.
REQ-009 SHALL have imm  input  XLEN  sign-extended immediate.
REQ-010 SHALL have rs1_val, rs2_val  input  XLEN each  source operands.
REQ-011 SHALL have rd  input  5  destination register index.
REQ-012 SHALL have origin_pc  output  1  redirect request to fetch.
REQ-013 SHALL have pc_branch  output  32  redirect target.
REQ-014 SHALL have squash  output  1  current input slot is wrong-path.
REQ-015 SHALL have link_we, link_rd, link_data  output  1/5/XLEN  return-address write.
REQ-016 SHALL have misalign  output  1  taken target not word-aligned.
REQ-017 SHALL have br_count, taken_count  output  16 each  performance counters.

Function
REQ-018 SHALL act on an instruction only when in_valid=1, is_branch=1, state=IDLE and code[11:10]!=11.
REQ-019 SHALL evaluate conditional funct3 as 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU; other funct3 values are not taken.
REQ-020 SHALL compute target = pc_in+imm for conditional and JAL, and (rs1_val+imm) with bit0 cleared for JALR; all sums modulo 2^32.
REQ-021 SHALL always treat JAL and JALR as taken.
REQ-022 SHALL, on a taken decision with target[1:0]=00 at posedge k, drive origin_pc=1 and pc_branch=target during cycle k only, then enter FLUSH.
REQ-023 SHALL, on a taken decision with target[1:0]!=00, pulse misalign for one cycle, suppress origin_pc and link_we, and remain in IDLE.
REQ-024 SHALL, for JAL/JALR with rd!=0, pulse link_we with link_rd=rd and link_data=pc_in+4 in the same cycle as origin_pc.
REQ-025 SHALL, in FLUSH, hold squash=1 and origin_pc=0 for exactly FLUSH_CYCLES cycles using a down-counter, ignore every input, then return to IDLE.
REQ-026 SHALL never assert origin_pc in two consecutive cycles.
REQ-027 SHALL increment br_count on every acted-on instruction, and taken_count on every taken one, each saturating at 16'hFFFF.
REQ-028 SHALL leave pc_branch holding its last value when origin_pc=0.

Reset
REQ-029 SHALL, on reset, set state=IDLE, flush counter=0, origin_pc=0, pc_branch=0, squash=0, link_we=0, link_rd=0, link_data=0, misalign=0, br_count=0 and taken_count=0.
REQ-030 SHALL give reset priority over a concurrent branch: a redirect in progress is cancelled, and no origin_pc pulse is issued in the cycle after reset.

Structure
REQ-031 SHALL take the class encodings, funct3 constants and state encodings (IDLE, FLUSH) from the shared core package.
REQ-032 SHALL place the condition evaluation in one combinational sub-module, branch_cmp.

Verification
REQ-033 Bench SHALL check: BEQ, pc_in=0x100, imm=0x20, rs1=rs2=5 -> origin_pc=1, pc_branch=0x120 for one cycle, then squash=1 for 1 cycle.
REQ-034 Bench SHALL check: BLT, rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU with the same operands -> not taken, origin_pc=0, and br_count increments by 2 while taken_count increments by 1.
REQ-035 Bench SHALL check: JALR, rs1=0x203, imm=0, rd=1 -> pc_branch=0x202, misalign=1, origin_pc=0, link_we=0.
REQ-036 Bench SHALL check: JAL, pc_in=0x40, imm=0x10, rd=5 -> pc_branch=0x50, link_we=1, link_rd=5, link_data=0x44; a branch presented during FLUSH is ignored.
REQ-037 Bench SHALL check: FLUSH_CYCLES=3 with back-to-back taken branches -> squash high for 3 cycles, and the next redirect occurs only after that.
REQ-038 Bench SHALL check: reset asserted during FLUSH -> all outputs 0 the next cycle; 65536 taken branches -> both counters hold 0xFFFF.
